// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory request/response port between IFU (read-only) and LSU.
// One transaction in flight; request fields are latched at grant and held until memory accepts.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  input  logic            ifu_resp_ready,
  output logic [DW-1:0]   ifu_rdata,
  output logic            ifu_resp_err,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  input  logic            lsu_resp_ready,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_resp_err
);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t        state;
  logic          owner_lsu;
  logic          last_lsu;
  logic [TW-1:0] timer;

  logic grant_ifu, grant_lsu, owner_ready, resp_act, timeout;

  // On a tie the master that did not win last time is served.
  assign grant_ifu = !rst && (state == IDLE) && ifu_req_valid && (!lsu_req_valid || last_lsu);
  assign grant_lsu = !rst && (state == IDLE) && lsu_req_valid && (!ifu_req_valid || !last_lsu);

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;
  assign mem_req_valid  = (state == REQ);
  assign owner_ready    = owner_lsu ? lsu_resp_ready : ifu_resp_ready;
  assign mem_resp_ready = (state == RESP) && owner_ready;
  assign resp_act       = (state == RESP) && mem_resp_valid;

  // Timer holds TIMEOUT-2 in the last cycle before the error response must appear.
  assign timeout = (timer >= TW'(TIMEOUT - 2));

  assign ifu_resp_valid = !owner_lsu && ((state == ERR) || resp_act);
  assign lsu_resp_valid =  owner_lsu && ((state == ERR) || resp_act);
  assign ifu_resp_err   = !owner_lsu && ((state == ERR) || (resp_act && mem_resp_err));
  assign lsu_resp_err   =  owner_lsu && ((state == ERR) || (resp_act && mem_resp_err));
  assign ifu_rdata      = (resp_act && !owner_lsu) ? mem_rdata : '0;
  assign lsu_rdata      = (resp_act &&  owner_lsu) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      last_lsu  <= 1'b1;
      timer     <= '0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state)
        IDLE: if (grant_ifu || grant_lsu) begin
          owner_lsu <= grant_lsu;
          last_lsu  <= grant_lsu;
          timer     <= '0;
          mem_addr  <= grant_lsu ? lsu_addr : ifu_addr;
          mem_wen   <= grant_lsu && lsu_wen;
          mem_wdata <= grant_lsu ? lsu_wdata : '0;
          mem_wmask <= grant_lsu ? lsu_wmask : '0;
          state     <= REQ;
        end
        REQ: begin
          timer <= timer + TW'(1);
          if (mem_req_ready)  state <= RESP;
          else if (timeout)   state <= ERR;
        end
        RESP: begin
          timer <= timer + TW'(1);
          if (mem_resp_valid && mem_resp_ready) state <= IDLE;
          else if (timeout)                     state <= ERR;
        end
        ERR: if (owner_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
